// File: rtl/sobel_filter_stream.sv
// rtl/sobel_filter_stream.sv - streaming 3x3 Sobel edge detector, LANES pixels per beat, ready/valid flow control
// Optional feature macro: SOBEL_THRESHOLD_EN (adds a per-beat binarising threshold input).
module sobel_filter_stream #(
    parameter int PIX_W     = 8,
    parameter int LANES     = 16,
    parameter int IMG_WIDTH = 640
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sof_in,
    input  logic [LANES*PIX_W-1:0] data_in,
    input  logic                   valid_in,
    output logic                   ready_in,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIX_W-1:0]       threshold,
`endif
    output logic [LANES*PIX_W-1:0] data_out,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic                   sof_out
);
    localparam int BEATS = IMG_WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BW    = LANES * PIX_W;
    localparam int XW    = (LANES + 2) * PIX_W;
    localparam int SW    = PIX_W + 3;
    localparam int AW    = PIX_W + 2;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    logic          adv;
    logic          accept;
    logic [CW-1:0] col_beat;
    logic [1:0]    row;
    logic [CW-1:0] eff_col;
    logic [1:0]    eff_row;

    // One global enable: the whole pipeline moves only when the output slot can drain.
    assign adv      = !valid_out || ready_out;
    assign ready_in = adv;
    assign accept   = valid_in && adv;
    assign eff_col  = sof_in ? '0 : col_beat;
    assign eff_row  = sof_in ? 2'd0 : row;

    logic [BW-1:0] lb1 [BEATS];
    logic [BW-1:0] lb2 [BEATS];
    logic [BW-1:0] lb1_rd;
    logic [BW-1:0] lb2_rd;

    assign lb1_rd = lb1[eff_col];
    assign lb2_rd = lb2[eff_col];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[eff_col] <= data_in;
            lb2[eff_col] <= lb1_rd;
        end
    end

    logic [2*PIX_W-1:0] ctx0, ctx1, ctx2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_beat <= '0;
            row      <= 2'd0;
            ctx0     <= '0;
            ctx1     <= '0;
            ctx2     <= '0;
        end else if (accept) begin
            ctx0 <= data_in[BW-1 -: 2*PIX_W];
            ctx1 <= lb1_rd[BW-1 -: 2*PIX_W];
            ctx2 <= lb2_rd[BW-1 -: 2*PIX_W];
            if (eff_col == CW'(BEATS - 1)) begin
                col_beat <= '0;
                row      <= (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
            end else begin
                col_beat <= eff_col + CW'(1);
                row      <= eff_row;
            end
        end
    end

    // Stage 1: 3 rows x (LANES+2) columns; index 0/1 hold the previous beat's last two pixels.
    logic          s1_valid, s1_sof, s1_row_mask, s1_first;
    logic [XW-1:0] s1_p0, s1_p1, s1_p2;
`ifdef SOBEL_THRESHOLD_EN
    logic [PIX_W-1:0] s1_thr, s2_thr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sof      <= 1'b0;
            s1_row_mask <= 1'b1;
            s1_first    <= 1'b1;
            s1_p0       <= '0;
            s1_p1       <= '0;
            s1_p2       <= '0;
`ifdef SOBEL_THRESHOLD_EN
            s1_thr      <= '0;
`endif
        end else if (adv) begin
            s1_valid    <= accept;
            s1_sof      <= accept && sof_in;
            s1_row_mask <= (eff_row < 2'd2);
            s1_first    <= (eff_col == '0);
            s1_p0       <= {data_in, ctx0};
            s1_p1       <= {lb1_rd, ctx1};
            s1_p2       <= {lb2_rd, ctx2};
`ifdef SOBEL_THRESHOLD_EN
            s1_thr      <= threshold;
`endif
        end
    end

    function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b,
                                           input logic [PIX_W-1:0] c);
        return SW'(a) + (SW'(b) << 1) + SW'(c);
    endfunction

    function automatic logic [AW-1:0] adiff(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic signed [SW-1:0] d;
        d = $signed(a) - $signed(b);
        return d[SW-1] ? AW'(-d) : AW'(d);
    endfunction

    function automatic logic [PIX_W-1:0] px(input logic [XW-1:0] v, input int idx);
        return v[idx*PIX_W +: PIX_W];
    endfunction

    logic [LANES-1:0][AW-1:0] ax_c, ay_c;

    always_comb begin
        ax_c = '0;
        ay_c = '0;
        for (int l = 0; l < LANES; l++) begin
            ax_c[l] = adiff(wsum(px(s1_p2, l + 2), px(s1_p1, l + 2), px(s1_p0, l + 2)),
                            wsum(px(s1_p2, l), px(s1_p1, l), px(s1_p0, l)));
            ay_c[l] = adiff(wsum(px(s1_p0, l), px(s1_p0, l + 1), px(s1_p0, l + 2)),
                            wsum(px(s1_p2, l), px(s1_p2, l + 1), px(s1_p2, l + 2)));
            if (s1_row_mask || (s1_first && l < 2)) begin
                ax_c[l] = '0;
                ay_c[l] = '0;
            end
        end
    end

    logic                     s2_valid, s2_sof;
    logic [LANES-1:0][AW-1:0] s2_ax, s2_ay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_ax    <= '0;
            s2_ay    <= '0;
`ifdef SOBEL_THRESHOLD_EN
            s2_thr   <= '0;
`endif
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_ax    <= ax_c;
            s2_ay    <= ay_c;
`ifdef SOBEL_THRESHOLD_EN
            s2_thr   <= s1_thr;
`endif
        end
    end

    function automatic logic [PIX_W-1:0] sat_mag(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(PIX_MAX)) ? PIX_MAX : s[PIX_W-1:0];
    endfunction

    logic [BW-1:0] out_c;

    always_comb begin
        out_c = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef SOBEL_THRESHOLD_EN
            out_c[l*PIX_W +: PIX_W] = (sat_mag(s2_ax[l], s2_ay[l]) > s2_thr) ? PIX_MAX : '0;
`else
            out_c[l*PIX_W +: PIX_W] = sat_mag(s2_ax[l], s2_ay[l]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            data_out  <= '0;
        end else if (adv) begin
            valid_out <= s2_valid;
            sof_out   <= s2_sof;
            data_out  <= out_c;
        end
    end
endmodule

// File: doc/sobel_filter_stream.md
# sobel_filter_stream

- Parametrised streaming Sobel edge detector. Successor to the fixed 128-bit `sobel_filter`.
- Accepts LANES pixels per beat and keeps two line buffers internally, so it computes a full 3x3 window at line rate.
- Adds ready/valid backpressure and frame alignment.
- Sits between the pixel unpacker and the output DMA in the image pipeline.

## Interface
- `PIX_W`, 8: bits per pixel.
- `LANES`, 16: pixels per beat. Bus width is LANES*PIX_W (default 128).
- `IMG_WIDTH`, 640: pixels per line. Must be a multiple of LANES and at least 2*LANES.
- `clk` input, 1: sole clock. All logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `sof_in` input, 1: marks the first beat of a frame. Qualified by `valid_in`.
- `data_in` input, LANES*PIX_W: lane 0 = bits [PIX_W-1:0] = leftmost pixel.
- `valid_in` input, 1: a beat is offered.
- `ready_in` output, 1: the block accepts the beat this cycle.
- `data_out` output, LANES*PIX_W: gradient magnitudes, same lane order as `data_in`.
- `valid_out` output, 1: an output beat is presented.
- `ready_out` input, 1: the downstream block accepts the output beat.
- `sof_out` output, 1: the output beat corresponds to an input beat that carried `sof_in`.

## Operation
- **Beat transfers:** a beat transfers when `valid` and `ready` are both high on a rising edge.
- **Counters:** `col_beat` (0..IMG_WIDTH/LANES-1) and `row` (saturates at 2) advance on each accepted input beat.
  - An accepted beat with `sof_in`=1 is treated as row 0, beat 0, regardless of the counter values.
  - `col_beat` wraps to 0 at the end of a line, and `row` then increments.
- **Line buffers:** two memories of IMG_WIDTH/LANES words each, holding lines r-1 and r-2. The current beat is written to the line r-1 buffer, and the old value moves to the line r-2 buffer.
- **Column context:** the last two pixels of the previous beat are registered for each of the 3 rows. For col_beat=0 this context is ignored.
- **Output pixel definition:** output pixel (r,c) is the Sobel response of the window centred at input pixel (r-1,c-1).
  - The value is forced to 0 when r<2 or c<2.
  - Output beat count per frame equals input beat count.
- **Arithmetic:**
  - Gx = (p[r-2][c] + 2p[r-1][c] + p[r][c]) - (same for column c-2).
  - Gy = (p[r][c-2] + 2p[r][c-1] + p[r][c]) - (same for row r-2).
  - Both use PIX_W+3 bit signed arithmetic.
  - Magnitude = |Gx|+|Gy|, saturated to 2^PIX_W-1.
- **Flow control:** the pipeline is 2 stages with a global stall. `ready_in` = !`valid_out` || `ready_out`. When stalled, the whole pipeline, the line buffers and the counters hold.

## Timing
- **Reset:** `rst_n` low clears the following asynchronously.
  - `valid_out`=0, `sof_out`=0, `data_out`=0.
  - `ready_in` = 1 as soon as reset is released.
  - Counters = 0, row=0; all pipeline valids = 0.
  - Line-buffer contents are don't-care, because the row<2 masking covers them.
- **Latency:** a beat accepted at rising edge n presents `valid_out`=1 after edge n+2 if no stall occurs. Throughput is 1 beat/cycle.
- **Output stability:** while `valid_out`=1 and `ready_out`=0, `data_out`, `sof_out` and `valid_out` hold unchanged.
- **Simultaneous events:** output drain and a new input can occur in the same cycle. `sof_in` on the last beat of a line takes priority over the wrap.
- **Reset mid-frame:** in-flight beats are discarded. The next accepted beat is row 0 even without `sof_in`.

## Configuration
- `SOBEL_THRESHOLD_EN` defined:
  - Adds the input port `threshold` [PIX_W-1:0], sampled when a beat is accepted and travelling with it through the pipeline.
  - Each output pixel = 2^PIX_W-1 if magnitude > `threshold`, else 0. Masked border pixels stay 0.
- `SOBEL_THRESHOLD_EN` undefined: the `threshold` port is absent and the saturated magnitude is output.

## Test plan
All scenarios use PIX_W=8, LANES=16, IMG_WIDTH=32 (2 beats/line).
- **Reset:** hold `rst_n`=0 with random inputs.
  - During reset: `valid_out`=0, `data_out`=0, `sof_out`=0.
  - After release: `ready_in`=1.
- **Flat image:** 4 rows of all pixels = 100 with `sof_in` on beat 0, `ready_out`=1.
  - Expect 8 output beats, all 0.
  - `sof_out` on the first output beat, 2 cycles after it is accepted.
- **Vertical edge:** columns 0-15 = 0, columns 16-31 = 200, 4 rows.
  - Rows 2-3: output columns 16 and 17 = 255 (|Gx|=800, saturated).
  - All other output pixels = 0.
- **Horizontal step:** row 0 = 0, rows 1-3 = 10.
  - Row 2, columns 2-31 = 40.
  - Row 2, columns 0-1 = 0.
  - Row 3 = 0.
- **Backpressure:** stream the vertical-edge image with `ready_out`=0 for 5 cycles mid-frame.
  - `ready_in` drops within the same cycle.
  - `data_out` stays stable during the stall.
  - Output sequence is identical to the unstalled run; no beat lost or duplicated.
- **Re-alignment:**
  - `sof_in` on beat 1 of row 1 restarts a new frame; its rows 0-1 are 0.
  - `rst_n` pulse mid-frame: no `valid_out` for the discarded beats; the next frame matches the golden output.
  - Threshold build with `threshold`=30 on the horizontal-step image: row 2 columns 2-31 = 255, all else 0.
